test_port_writer: RTL and testbench

//  Bus-master that reports a result block to the simulation test port as a stream of
//  D-memory writes: BEGIN_SYM, then NUM_WORDS result words read from a source RAM, then END_SYM.

---
 rtl/test_port_writer_pkg.sv | 28 ++
 rtl/test_port_writer_if.sv | 22 ++
 rtl/test_port_writer_write_port.sv | 36 +++
 rtl/test_port_writer.sv | 121 ++++++++++++
 tb/tb_test_port_writer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/test_port_writer_pkg.sv
// Shared constants, state encoding and byte-order helper for the test-port writer
// and the answer-checker that listens on the other end of the D-memory bus.
package test_port_writer_pkg;

    localparam logic [29:0] TEST_PORT = 30'h10;
    localparam logic [31:0] BEGIN_SYM = 32'h00000168;
    localparam logic [31:0] END_SYM   = 32'hFFFFFD5D;

    localparam int NUM_WORDS_DEF = 18;
    localparam int IDX_W_DEF     = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_BEGIN = 3'd1,
        ST_GAP      = 3'd2,
        ST_FETCH    = 3'd3,
        ST_LOAD     = 3'd4,
        ST_WR_DATA  = 3'd5,
        ST_WR_END   = 3'd6,
        ST_DONE     = 3'd7
    } tpw_state_t;

    // Readable-order word to the little-endian byte order the memory bus expects.
    function automatic logic [31:0] swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/test_port_writer_if.sv
// D-memory write bus plus the source-RAM read port used by the test-port writer.
interface test_port_writer_if #(
    parameter int IDX_W = 5
);
    logic             src_ren;
    logic [IDX_W-1:0] src_idx;
    logic [31:0]      src_data;
    logic             mem_stall;
    logic [29:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_wen;

    modport master (
        output src_ren, src_idx, mem_addr, mem_wdata, mem_wen,
        input  src_data, mem_stall
    );

    modport slave (
        input  src_ren, src_idx, mem_addr, mem_wdata, mem_wen,
        output src_data, mem_stall
    );
endinterface

// File: rtl/test_port_writer_write_port.sv
// Write-port register stage: launches one write, holds it through D-cache stalls and
// drops mem_wen for the cycle after completion so the checker sees each write once.
module tpw_write_port
    import test_port_writer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_go,
    input  logic [31:0] wr_data,
    input  logic        mem_stall,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic        complete
);

    assign complete = mem_wen && !mem_stall;

    // Launch on wr_go, hold while stalled, clear mem_wen once the write is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (wr_go) begin
                mem_wen   <= 1'b1;
                mem_addr  <= TEST_PORT;
                mem_wdata <= wr_data;
            end else if (complete) begin
                mem_wen   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/test_port_writer.sv
// Test-port writer: streams BEGIN_SYM, NUM_WORDS source-RAM words and END_SYM to the
// simulation test port as D-memory writes, one write per GAP-separated slot.
module test_port_writer
    import test_port_writer_pkg::*;
#(
    parameter int NUM_WORDS = NUM_WORDS_DEF,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    test_port_writer_if.master bus,
    output logic               busy,
    output logic               done,
    output logic [IDX_W:0]     words_sent
);

    tpw_state_t     state_q, state_d;
    logic [IDX_W:0] idx_q, idx_d;
    logic           end_q, end_d;
    logic           wr_go;
    logic [31:0]    wr_data;
    logic           complete;

    // idx doubles as the completed-word count reported on words_sent.
    assign words_sent = idx_q;

    tpw_write_port u_write_port (
        .clk       (clk),
        .rst       (rst),
        .wr_go     (wr_go),
        .wr_data   (wr_data),
        .mem_stall (bus.mem_stall),
        .mem_addr  (bus.mem_addr),
        .mem_wdata (bus.mem_wdata),
        .mem_wen   (bus.mem_wen),
        .complete  (complete)
    );

    // State, index and registered status/fetch outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            end_q       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bus.src_ren <= 1'b0;
            bus.src_idx <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            end_q       <= end_d;
            busy        <= (state_d != ST_IDLE) && (state_d != ST_DONE);
            done        <= (state_d == ST_DONE);
            bus.src_ren <= (state_d == ST_FETCH);
            if (state_d == ST_FETCH) begin
                bus.src_idx <= idx_q[IDX_W-1:0];
            end
        end
    end

    // Next-state logic; each write is launched on the transition into its WR_* state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        end_d   = end_q;
        wr_go   = 1'b0;
        wr_data = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WR_BEGIN;
                    idx_d   = '0;
                    end_d   = 1'b0;
                    wr_go   = 1'b1;
                    wr_data = swap32(BEGIN_SYM);
                end
            end
            ST_WR_BEGIN: begin
                if (complete) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (end_q) begin
                    state_d = ST_DONE;
                end else if (idx_q < (IDX_W+1)'(NUM_WORDS)) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WR_END;
                    wr_go   = 1'b1;
                    wr_data = swap32(END_SYM);
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_WR_DATA;
                wr_go   = 1'b1;
                wr_data = swap32(bus.src_data);
            end
            ST_WR_DATA: begin
                if (complete) begin
                    state_d = ST_GAP;
                    idx_d   = idx_q + (IDX_W+1)'(1);
                end
            end
            ST_WR_END: begin
                if (complete) begin
                    state_d = ST_GAP;
                    end_d   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_test_port_writer.sv
// Bench for test_port_writer: source-RAM model, stall agent and write scoreboard.
module tb_test_port_writer;

    localparam int N     = 18;
    localparam int IW    = 5;
    localparam int LAT   = 2 + 4*N + 3;   // BEGIN+GAP, 4 per word, END+GAP+DONE

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done;
    logic [IW:0] words_sent;

    test_port_writer_if #(.IDX_W(IW)) bus ();

    test_port_writer #(.NUM_WORDS(N), .IDX_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] src_mem[32];
    int          wr_idx = 0;
    int          last_wr_cnt = 0;
    int          done_cnt = 0;
    int          stall_a = -1, stall_b = -1, stall_len = 0, stall_cnt = 0;
    bit          pulse_mode = 0;
    bit          prev_stalled = 0, prev_complete = 0;
    logic [29:0] prev_addr;
    logic [31:0] prev_wdata;
    logic [31:0] first_data = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // Source RAM: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.src_ren) bus.src_data <= src_mem[bus.src_idx];
    end

    // Monitor + stall agent: decide stall for the coming edge, then score that edge.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            bus.mem_stall = 1'b0;
            wr_idx        = 0;
            stall_cnt     = 0;
            prev_stalled  = 0;
            prev_complete = 0;
        end else begin
            if (prev_stalled) begin
                check_eq("stall_wen",   {31'b0, bus.mem_wen}, 32'd1);
                check_eq("stall_addr",  {2'b0, bus.mem_addr}, {2'b0, prev_addr});
                check_eq("stall_wdata", bus.mem_wdata, prev_wdata);
            end
            if (prev_complete) check_eq("gap_wen", {31'b0, bus.mem_wen}, 32'd0);
            if (bus.src_ren) check_eq("src_idx", {27'b0, bus.src_idx}, 32'(wr_idx - 1));
            if (bus.mem_wen && (wr_idx == stall_a || wr_idx == stall_b) && stall_cnt < stall_len) begin
                bus.mem_stall = 1'b1;
                stall_cnt++;
            end else begin
                bus.mem_stall = pulse_mode && !bus.mem_wen;
            end
            prev_stalled  = bus.mem_wen && bus.mem_stall;
            prev_complete = bus.mem_wen && !bus.mem_stall;
            prev_addr     = bus.mem_addr;
            prev_wdata    = bus.mem_wdata;
            if (prev_complete) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("wdata", bus.mem_wdata, e);
                end
                check_eq("addr", {2'b0, bus.mem_addr}, 32'h10);
                if (wr_idx == 1) first_data = bus.mem_wdata;
                wr_idx++;
                stall_cnt = 0;
            end
            if (done) begin
                done_cnt++;
                check_eq("busy_in_done", {31'b0, busy}, 32'd0);
                last_wr_cnt = wr_idx;
                wr_idx      = 0;
            end
        end
    end

    task automatic push_expected();
        exp_q.push_back(bswap(32'h00000168));
        for (int i = 0; i < N; i++) exp_q.push_back(bswap(src_mem[i]));
        exp_q.push_back(bswap(32'hFFFFFD5D));
    endtask

    task automatic run_report(input string tag, input int exp_cyc, input int inj_cyc,
                              input bit start_in_done);
        int base;
        int cyc;
        base = done_cnt;
        cyc  = 0;
        push_expected();
        @(negedge clk);
        start = 1'b1;
        while (1) begin
            @(negedge clk);
            cyc++;
            start = (cyc == inj_cyc);
            if (done) break;
            if (cyc > 600) begin
                check_eq({tag, "_done_timeout"}, 32'd0, 32'd1);
                break;
            end
        end
        check_eq({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        check_eq({tag, "_words_sent"}, {26'b0, words_sent}, 32'(N));
        if (start_in_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq({tag, "_done_pulses"}, 32'(done_cnt - base), 32'd1);
        check_eq({tag, "_writes"}, 32'(last_wr_cnt), 32'(N + 2));
        check_eq({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
        check_eq({tag, "_wen_after"}, {31'b0, bus.mem_wen}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_wen"},        {31'b0, bus.mem_wen}, 32'd0);
        check_eq({tag, "_addr"},       {2'b0, bus.mem_addr}, 32'd0);
        check_eq({tag, "_wdata"},      bus.mem_wdata, 32'd0);
        check_eq({tag, "_src_ren"},    {31'b0, bus.src_ren}, 32'd0);
        check_eq({tag, "_src_idx"},    {27'b0, bus.src_idx}, 32'd0);
        check_eq({tag, "_busy"},       {31'b0, busy}, 32'd0);
        check_eq({tag, "_done"},       {31'b0, done}, 32'd0);
        check_eq({tag, "_words_sent"}, {26'b0, words_sent}, 32'd0);
    endtask

    initial begin
        int k;
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 32; i++) src_mem[i] = '0;
        src_mem[1] = 32'h0000FFFF;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Plain report, no stalls.
        run_report("nostall", LAT, 0, 0);

        // Byte order plus 3-cycle stalls on BEGIN and on word 5.
        for (int i = 0; i < 32; i++) src_mem[i] = $urandom;
        src_mem[0] = 32'h11223344;
        stall_a = 0; stall_b = 6; stall_len = 3;
        run_report("stall", LAT + 6, 0, 0);
        stall_a = -1; stall_b = -1; stall_len = 0;
        check_eq("byte_order", first_data, 32'h44332211);

        // Stall held while mem_wen is low must not shift timing.
        pulse_mode = 1;
        run_report("pulse", LAT, 0, 0);
        pulse_mode = 0;
        repeat (2) @(negedge clk);

        // start re-asserted during word 7 and during DONE.
        run_report("restart", LAT, 2 + 4*7 + 2, 1);

        // Reset during the word-10 write, then a full fresh report.
        push_expected();
        @(negedge clk);
        start = 1'b1;
        k = 0;
        @(negedge clk);
        start = 1'b0;
        while (!(words_sent == 10 && bus.mem_wen) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_eq("word10_reached", 32'(k < 200), 32'd1);
        #1 rst = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_words_sent", {26'b0, words_sent}, 32'd0);
        run_report("fresh", LAT, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
